calc_expr_eval: RTL and testbench
=================================

Name: calc_expr_eval

Overview:
Streaming ASCII arithmetic expression evaluator: one character per valid cycle, e.g. "12*34-5=". Supports multi-digit operands, operators + - *, standard precedence (* before + -), and '=' as terminator. Parametrised successor to the single-digit calculate block, adding configurable width, radix, input qualification, completion and error signalling. Sits between a character source (UART/keypad/testbench) and a display or result register.

Parameters:
WIDTH, 32, datapath/result width; all arithmetic two's complement modulo 2^WIDTH
RADIX, 10, operand radix; legal values 10 or 16 (16 also accepts '0'-'9','a'-'f','A'-'F')

Ports:
clk  input  1  clock, rising edge
clr  input  1  synchronous active-high reset
in  input  8  ASCII character
in_valid  input  1  in is consumed on a rising edge where in_valid=1
out  output  WIDTH  running value of the expression so far; final result after '='
done  output  1  one-cycle pulse: expression terminated by '='
err  output  1  sticky syntax error flag

Behaviour:
- Reset: clr=1 at a clock edge -> state EXPECT_NUM, sum=0, term=0, num=0, sign=+, mul_pend=0, out=0, done=0, err=0. clr wins over in_valid in the same cycle, including mid-expression.
- Latency: a character accepted at edge t is reflected in out/done/err immediately after edge t (one registered stage). With in_valid=0: all state held, done=0.
- Character classes: digit (per RADIX), '+', '-', '*', '=', space (0x20, ignored in every state, no state change), anything else -> invalid.
- Internal registers: sum (committed additive total), term (pending product left operand), num (current operand), sign (+/-), mul_pend.
- val = mul_pend ? term*num : num (WIDTH-bit truncated).
- States:
  EXPECT_NUM: digit -> num=digit, go IN_NUM. Operator, '=' or invalid -> ERR.
  IN_NUM: digit -> num=num*RADIX+digit (wraps). '*' -> term=val, mul_pend=1, num=0, go EXPECT_NUM. '+'/'-' -> sum=sum±val per sign, sign=new op, mul_pend=0, num=0, go EXPECT_NUM. '=' -> out=sum±val, done=1, clear sum/term/num/sign/mul_pend, go EXPECT_NUM. Invalid -> ERR.
  ERR: err=1 held; all chars ignored except '=' -> done=1, out=0, err cleared on the following cycle, go EXPECT_NUM. clr also exits.
- out update on every accepted char outside ERR (except '=' and space): out = sum ± (mul_pend ? term*num : num) using the post-update registers, i.e. the value the expression would have if terminated now. After '=' out holds the result until the next accepted digit. On entry to ERR out=0.
- done high exactly one cycle per '='; err and done both high in the ERR-terminate cycle.
- No leading unary minus: "-3=" is an error. Overflow wraps silently; no overflow flag.
- Multipliers: two WIDTH x WIDTH truncated products (num*RADIX is shift/add; term*num is a real multiplier) in a single cycle.

Decomposition:
- Package calc_pkg: ASCII constants (CH_PLUS, CH_MINUS, CH_STAR, CH_EQ, CH_SPACE), state enum {EXPECT_NUM, IN_NUM, ERR}, character-class enum {CLS_DIGIT, CLS_ADD, CLS_SUB, CLS_MUL, CLS_EQ, CLS_SPACE, CLS_BAD}.
- Sub-module calc_char_decode (combinational, parameter RADIX): in -> class, 4-bit digit value. Top holds the FSM and datapath.

Test Plan:
- Defaults, "1+2*3+2*4=" one char per cycle -> out after '=' = 15, done pulse one cycle; out before '=' = 15 after '4' as well (running).
- "12*34-5=" -> 403; "7-10=" -> 0xFFFFFFFD, err=0.
- "3+*4=" -> err=1 after '*', '4' ignored, '=' gives done=1 with out=0, err=0 next cycle; then "2*2=" -> 4.
- clr asserted after "5*6" with in_valid=1 on same edge -> out=0, err=0, no done; following "9=" -> 9.
- RADIX=16: "ff+1=" -> 0x100; "A*b=" -> 0x6E. WIDTH=8, RADIX=10: "200+100=" -> 44 (wrap).
- Gaps and spaces: "4 * 5" with in_valid low for 3 cycles between chars, then "=" -> 20, state unchanged during gaps.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants and enums for the streaming ASCII expression evaluator.
package calc_pkg;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    EXPECT_NUM = 2'd0,
    IN_NUM     = 2'd1,
    ERR        = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CLS_DIGIT = 3'd0,
    CLS_ADD   = 3'd1,
    CLS_SUB   = 3'd2,
    CLS_MUL   = 3'd3,
    CLS_EQ    = 3'd4,
    CLS_SPACE = 3'd5,
    CLS_BAD   = 3'd6
  } cls_t;

endpackage

// File: rtl/calc_char_decode.sv
// Combinational ASCII classifier: character class plus 4-bit digit value.
module calc_char_decode
  import calc_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic [7:0] in,
  output cls_t       cls,
  output logic [3:0] dig
);

  // Classify one character; hex letters share the low-nibble+9 mapping.
  always_comb begin
    cls = CLS_BAD;
    dig = 4'd0;
    if (in >= 8'h30 && in <= 8'h39) begin
      cls = CLS_DIGIT;
      dig = in[3:0];
    end else if ((RADIX == 16) &&
                 ((in >= 8'h61 && in <= 8'h66) || (in >= 8'h41 && in <= 8'h46))) begin
      cls = CLS_DIGIT;
      dig = in[3:0] + 4'd9;
    end else begin
      case (in)
        CH_PLUS:  cls = CLS_ADD;
        CH_MINUS: cls = CLS_SUB;
        CH_STAR:  cls = CLS_MUL;
        CH_EQ:    cls = CLS_EQ;
        CH_SPACE: cls = CLS_SPACE;
        default:  cls = CLS_BAD;
      endcase
    end
  end

endmodule

// File: rtl/calc_expr_eval.sv
// Streaming ASCII expression evaluator with * over +/- precedence.
module calc_expr_eval
  import calc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADIX = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] RADIX_W = WIDTH'(RADIX);

  state_t           state_r;
  logic [WIDTH-1:0] sum_r, term_r, num_r, out_r;
  logic             sign_r, mul_pend_r, done_r, err_r;

  cls_t             cls_s;
  logic [3:0]       dig_s;
  logic [WIDTH-1:0] num_new_s, mul_b_s, prod_s, val_s, acc_s;

  function automatic logic [WIDTH-1:0] addsub(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             neg);
    return neg ? (a - b) : (a + b);
  endfunction

  calc_char_decode #(.RADIX(RADIX)) u_dec (
    .in  (in),
    .cls (cls_s),
    .dig (dig_s)
  );

  // Datapath: one shared multiplier; for digits it sees the updated operand,
  // otherwise the current one, so acc_s is always the "terminate now" value.
  always_comb begin
    num_new_s = (state_r == IN_NUM) ? (num_r * RADIX_W + WIDTH'(dig_s)) : WIDTH'(dig_s);
    mul_b_s   = (cls_s == CLS_DIGIT) ? num_new_s : num_r;
    prod_s    = term_r * mul_b_s;
    val_s     = mul_pend_r ? prod_s : mul_b_s;
    acc_s     = addsub(sum_r, val_s, sign_r);
  end

  // Parser FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r    <= EXPECT_NUM;
      sum_r      <= '0;
      term_r     <= '0;
      num_r      <= '0;
      sign_r     <= 1'b0;
      mul_pend_r <= 1'b0;
      out_r      <= '0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      // err survives only the terminate cycle once ERR has been left
      if (state_r != ERR) err_r <= 1'b0;
      if (in_valid) begin
        case (state_r)
          EXPECT_NUM: begin
            case (cls_s)
              CLS_DIGIT: begin
                num_r   <= num_new_s;
                out_r   <= acc_s;
                state_r <= IN_NUM;
              end
              CLS_SPACE: ;
              default: begin
                state_r <= ERR;
                err_r   <= 1'b1;
                out_r   <= '0;
              end
            endcase
          end
          IN_NUM: begin
            case (cls_s)
              CLS_DIGIT: begin
                num_r <= num_new_s;
                out_r <= acc_s;
              end
              CLS_MUL: begin
                term_r     <= val_s;
                mul_pend_r <= 1'b1;
                num_r      <= '0;
                out_r      <= sum_r;
                state_r    <= EXPECT_NUM;
              end
              CLS_ADD, CLS_SUB: begin
                sum_r      <= acc_s;
                sign_r     <= (cls_s == CLS_SUB);
                mul_pend_r <= 1'b0;
                num_r      <= '0;
                out_r      <= acc_s;
                state_r    <= EXPECT_NUM;
              end
              CLS_EQ: begin
                out_r      <= acc_s;
                done_r     <= 1'b1;
                sum_r      <= '0;
                term_r     <= '0;
                num_r      <= '0;
                sign_r     <= 1'b0;
                mul_pend_r <= 1'b0;
                state_r    <= EXPECT_NUM;
              end
              CLS_SPACE: ;
              default: begin
                state_r <= ERR;
                err_r   <= 1'b1;
                out_r   <= '0;
              end
            endcase
          end
          ERR: begin
            if (cls_s == CLS_EQ) begin
              done_r     <= 1'b1;
              out_r      <= '0;
              sum_r      <= '0;
              term_r     <= '0;
              num_r      <= '0;
              sign_r     <= 1'b0;
              mul_pend_r <= 1'b0;
              state_r    <= EXPECT_NUM;
            end
          end
          default: begin
            state_r <= ERR;
            err_r   <= 1'b1;
            out_r   <= '0;
          end
        endcase
      end
    end
  end

  assign out  = out_r;
  assign done = done_r;
  assign err  = err_r;

endmodule

// File: tb/tb_calc_expr_eval.sv
// Directed self-checking bench: decimal/32, hex/32 and decimal/8 instances.
module tb_calc_expr_eval;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  in = 8'h00;
  logic        in_valid = 1'b0;

  logic [31:0] out_a, out_b;
  logic [7:0]  out_c;
  logic        done_a, err_a, done_b, err_b, done_c, err_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  calc_expr_eval dut_a (.clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
                        .out(out_a), .done(done_a), .err(err_a));
  calc_expr_eval #(.WIDTH(32), .RADIX(16)) dut_b (.clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
                        .out(out_b), .done(done_b), .err(err_b));
  calc_expr_eval #(.WIDTH(8), .RADIX(10)) dut_c (.clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
                        .out(out_c), .done(done_c), .err(err_c));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_ch(input logic [7:0] c);
    @(negedge clk);
    in = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_ch(s[i]);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    do_clr();
    chk("rst_out", out_a, 64'd0);
    chk("rst_done", done_a, 64'd0);
    chk("rst_err", err_a, 64'd0);

    // precedence with running value
    send_str("1+2*3+2*4");
    chk("prec_running", out_a, 64'd15);
    chk("prec_nodone", done_a, 64'd0);
    send_ch("=");
    chk("prec_out", out_a, 64'd15);
    chk("prec_done", done_a, 64'd1);
    idle();
    chk("prec_done_pulse", done_a, 64'd0);
    chk("prec_hold", out_a, 64'd15);

    do_clr();
    send_str("12*34-5=");
    chk("multi_digit", out_a, 64'd403);

    do_clr();
    send_str("7-10=");
    chk("neg_wrap", out_a, 64'hFFFF_FFFD);
    chk("neg_wrap_err", err_a, 64'd0);

    // syntax error, recovery via '='
    do_clr();
    send_str("3+*");
    chk("err_set", err_a, 64'd1);
    chk("err_out0", out_a, 64'd0);
    send_ch("4");
    chk("err_ignore", out_a, 64'd0);
    chk("err_sticky", err_a, 64'd1);
    send_ch("=");
    chk("err_term_done", done_a, 64'd1);
    chk("err_term_err", err_a, 64'd1);
    chk("err_term_out", out_a, 64'd0);
    idle();
    chk("err_cleared", err_a, 64'd0);
    chk("err_done_low", done_a, 64'd0);
    send_str("2*2=");
    chk("after_err", out_a, 64'd4);

    // clr wins over in_valid mid-expression
    do_clr();
    send_str("5*6");
    chk("pre_clr_run", out_a, 64'd30);
    @(negedge clk);
    clr = 1'b1;
    in = "7";
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_out", out_a, 64'd0);
    chk("clr_err", err_a, 64'd0);
    chk("clr_done", done_a, 64'd0);
    send_str("9=");
    chk("post_clr", out_a, 64'd9);

    do_clr();
    send_ch("-");
    chk("unary_minus_err", err_a, 64'd1);

    do_clr();
    send_str("ff+1=");
    chk("hex_ff1", out_b, 64'h100);
    send_str("A*b=");
    chk("hex_mul", out_b, 64'h6E);
    chk("hex_done", done_b, 64'd1);

    do_clr();
    send_str("200+100=");
    chk("w8_wrap", out_c, 64'd44);

    // gaps and spaces
    do_clr();
    send_ch("4");
    for (int i = 0; i < 3; i++) idle();
    chk("gap_hold", out_a, 64'd4);
    send_ch(" ");
    chk("space_hold", out_a, 64'd4);
    send_ch("*");
    for (int i = 0; i < 3; i++) idle();
    chk("gap_after_mul", out_a, 64'd0);
    chk("gap_err", err_a, 64'd0);
    send_ch(" ");
    send_ch("5");
    chk("gap_running", out_a, 64'd20);
    send_ch("=");
    chk("gap_result", out_a, 64'd20);
    chk("gap_done", done_a, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
